// File: rtl/counter_scan_controller_if.sv
// Button pulses into the counter controller and the multiplexed display pins out of it.
interface counter_scan_controller_if;
    logic       START;
    logic       STOP;
    logic       CLEAR;
    logic [3:0] AN;
    logic [6:0] SEG;
    logic       DP;
    logic       RUNNING;
    logic       CARRY;

    modport master (output START, STOP, CLEAR, input AN, SEG, DP, RUNNING, CARRY);
    modport slave  (input START, STOP, CLEAR, output AN, SEG, DP, RUNNING, CARRY);
endinterface

// File: rtl/counter_scan_controller.sv
// Start/stop/clear sequencing of a 4-digit BCD up-counter, with a free-running
// digit scan that drives an active-low seven-segment display.
module counter_scan_controller #(
    parameter int unsigned COUNT_DIV = 20000000,
    parameter int unsigned SCAN_DIV  = 50000
) (
    input  logic CLK,
    input  logic RST,
    counter_scan_controller_if.slave bus
);
    localparam int CDW = $clog2(COUNT_DIV);
    localparam int SDW = $clog2(SCAN_DIV);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

    state_t          state;
    state_t          state_next;
    logic            start_q;
    logic            stop_q;
    logic            clear_q;
    logic [CDW-1:0]  div;
    logic [CDW-1:0]  div_next;
    logic [3:0][3:0] bcd;
    logic [3:0][3:0] bcd_next;
    logic [3:0][3:0] bcd_inc;
    logic            bcd_wrap;
    logic            carry_next;
    logic            terminal;
    logic [SDW-1:0]  scan_div;
    logic [1:0]      idx;

    function automatic logic [6:0] seg_code(input logic [3:0] digit);
        case (digit)
            4'd0:    seg_code = 7'b1000000;
            4'd1:    seg_code = 7'b1111001;
            4'd2:    seg_code = 7'b0100100;
            4'd3:    seg_code = 7'b0110000;
            4'd4:    seg_code = 7'b0011001;
            4'd5:    seg_code = 7'b0010010;
            4'd6:    seg_code = 7'b0000010;
            4'd7:    seg_code = 7'b1111000;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0010000;
            default: seg_code = 7'b1111111;
        endcase
    endfunction

    // Button pulses are registered once, so the FSM reacts one edge after sampling them.
    always_ff @(posedge CLK) begin
        if (RST) begin
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            start_q <= bus.START;
            stop_q  <= bus.STOP;
            clear_q <= bus.CLEAR;
        end
    end

    assign terminal = (div == CDW'(COUNT_DIV - 1));

    always_comb begin
        bcd_inc  = bcd;
        bcd_wrap = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (bcd_wrap) begin
                if (bcd[i] == 4'd9) begin
                    bcd_inc[i] = 4'd0;
                end else begin
                    bcd_inc[i] = bcd[i] + 4'd1;
                    bcd_wrap   = 1'b0;
                end
            end
        end
    end

    // CLEAR beats everything, including an increment due in the same cycle.
    always_comb begin
        state_next = state;
        div_next   = div;
        bcd_next   = bcd;
        carry_next = 1'b0;
        if (clear_q) begin
            state_next = IDLE;
            div_next   = '0;
            bcd_next   = '0;
        end else begin
            case (state)
                IDLE:    if (start_q && !stop_q) state_next = RUN;
                RUN:     if (stop_q) state_next = PAUSED;
                PAUSED:  if (start_q && !stop_q) state_next = RUN;
                default: state_next = IDLE;
            endcase
            if (state == RUN) begin
                if (terminal) begin
                    div_next   = '0;
                    bcd_next   = bcd_inc;
                    carry_next = bcd_wrap;
                end else begin
                    div_next = div + CDW'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            div         <= '0;
            bcd         <= '0;
            bus.CARRY   <= 1'b0;
            bus.RUNNING <= 1'b0;
        end else begin
            state       <= state_next;
            div         <= div_next;
            bcd         <= bcd_next;
            bus.CARRY   <= carry_next;
            bus.RUNNING <= (state_next == RUN);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            scan_div <= '0;
            idx      <= 2'd0;
        end else if (scan_div == SDW'(SCAN_DIV - 1)) begin
            scan_div <= '0;
            idx      <= idx + 2'd1;
        end else begin
            scan_div <= scan_div + SDW'(1);
        end
    end

    // Display pins follow the index and counter of the previous cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            bus.AN  <= 4'b1110;
            bus.SEG <= 7'b1000000;
            bus.DP  <= 1'b1;
        end else begin
            bus.AN  <= ~(4'b0001 << idx);
            bus.SEG <= seg_code(bcd[idx]);
            bus.DP  <= !((state == PAUSED) && (idx == 2'd0));
        end
    end
endmodule

// File: tb/tb_counter_scan_controller.sv
// Bench for counter_scan_controller: per-cycle scoreboard against a count-level model,
// plus a vector table and hand sequences for the timing corner cases.
module tb_counter_scan_controller;
    localparam int COUNT_DIV = 4;
    localparam int SCAN_DIV  = 2;
    localparam int M_IDLE    = 0;
    localparam int M_RUN     = 1;
    localparam int M_PAUSED  = 2;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       running;
        logic       carry;
    } outs_t;

    typedef struct {
        logic start;
        logic stop;
        logic clear;
        int   wait_n;
        logic exp_running;
        int   exp_count;
        logic exp_dp0;
    } vec_t;

    logic  CLK = 1'b0;
    logic  RST;
    int    errors = 0;
    int    checks = 0;
    int    carry_pulses = 0;
    outs_t sb_queue[$];
    int    m_state, m_div, m_count, m_scan_div, m_idx;
    logic  m_start_q, m_stop_q, m_clear_q;
    vec_t  vecs[8];
    logic [3:0] an_table[9];

    counter_scan_controller_if bus ();

    counter_scan_controller #(.COUNT_DIV(COUNT_DIV), .SCAN_DIV(SCAN_DIV)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    function automatic logic [6:0] encode_seg(input int d);
        case (d)
            0: encode_seg = 7'b1000000;
            1: encode_seg = 7'b1111001;
            2: encode_seg = 7'b0100100;
            3: encode_seg = 7'b0110000;
            4: encode_seg = 7'b0011001;
            5: encode_seg = 7'b0010010;
            6: encode_seg = 7'b0000010;
            7: encode_seg = 7'b1111000;
            8: encode_seg = 7'b0000000;
            default: encode_seg = 7'b0010000;
        endcase
    endfunction

    function automatic int decode_seg(input logic [6:0] s);
        case (s)
            7'b1000000: decode_seg = 0;
            7'b1111001: decode_seg = 1;
            7'b0100100: decode_seg = 2;
            7'b0110000: decode_seg = 3;
            7'b0011001: decode_seg = 4;
            7'b0010010: decode_seg = 5;
            7'b0000010: decode_seg = 6;
            7'b1111000: decode_seg = 7;
            7'b0000000: decode_seg = 8;
            7'b0010000: decode_seg = 9;
            default:    decode_seg = 15;
        endcase
    endfunction

    function automatic int digit_of(input int count, input int i);
        case (i)
            0: digit_of = count % 10;
            1: digit_of = (count / 10) % 10;
            2: digit_of = (count / 100) % 10;
            default: digit_of = (count / 1000) % 10;
        endcase
    endfunction

    // Count-level reference: the counter is a plain integer modulo 10000.
    always @(posedge CLK) begin
        outs_t e;
        int    n_state, n_div, n_count;
        logic  wrapped;
        if (RST) begin
            m_state <= M_IDLE; m_div <= 0; m_count <= 0; m_scan_div <= 0; m_idx <= 0;
            m_start_q <= 1'b0; m_stop_q <= 1'b0; m_clear_q <= 1'b0;
            e.an = 4'b1110; e.seg = 7'b1000000; e.dp = 1'b1; e.running = 1'b0; e.carry = 1'b0;
        end else begin
            n_state = m_state; n_div = m_div; n_count = m_count; wrapped = 1'b0;
            if (m_clear_q) begin
                n_state = M_IDLE; n_div = 0; n_count = 0;
            end else if (m_state == M_RUN) begin
                if (m_div == COUNT_DIV - 1) begin
                    n_div   = 0;
                    n_count = (m_count + 1) % 10000;
                    wrapped = (m_count == 9999);
                end else begin
                    n_div = m_div + 1;
                end
                if (m_stop_q) n_state = M_PAUSED;
            end else if (m_start_q && !m_stop_q) begin
                n_state = M_RUN;
            end
            e.an = 4'b1111;
            e.an[m_idx] = 1'b0;
            e.seg     = encode_seg(digit_of(m_count, m_idx));
            e.dp      = !(m_state == M_PAUSED && m_idx == 0);
            e.running = (n_state == M_RUN);
            e.carry   = wrapped;
            m_state <= n_state; m_div <= n_div; m_count <= n_count;
            m_start_q <= bus.START; m_stop_q <= bus.STOP; m_clear_q <= bus.CLEAR;
            if (m_scan_div == SCAN_DIV - 1) begin
                m_scan_div <= 0;
                m_idx      <= (m_idx + 1) % 4;
            end else begin
                m_scan_div <= m_scan_div + 1;
            end
        end
        sb_queue.push_back(e);
    end

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge CLK) begin
        outs_t e;
        if (bus.CARRY === 1'b1) carry_pulses++;
        if (sb_queue.size() > 0) begin
            e = sb_queue.pop_front();
            checkOutput("sb_an",      16'(bus.AN),      16'(e.an));
            checkOutput("sb_seg",     16'(bus.SEG),     16'(e.seg));
            checkOutput("sb_dp",      16'(bus.DP),      16'(e.dp));
            checkOutput("sb_running", 16'(bus.RUNNING), 16'(e.running));
            checkOutput("sb_carry",   16'(bus.CARRY),   16'(e.carry));
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic applyStimulus(input logic start, input logic stop, input logic clear);
        bus.START = start;
        bus.STOP  = stop;
        bus.CLEAR = clear;
        @(negedge CLK);
        bus.START = 1'b0;
        bus.STOP  = 1'b0;
        bus.CLEAR = 1'b0;
    endtask

    function automatic logic model_at(input int ts, input int td, input int tc);
        model_at = (ts < 0 || m_state == ts) && (td < 0 || m_div == td) && (tc < 0 || m_count == tc);
    endfunction

    task automatic waitForModel(input string name, input int ts, input int td, input int tc, input int limit);
        int n = 0;
        while (!model_at(ts, td, tc) && n < limit) begin
            @(negedge CLK);
            n++;
        end
        checkOutput(name, 16'(model_at(ts, td, tc)), 16'd1);
    endtask

    task automatic readDisplay(input string name, input int exp_count, input logic exp_dp0);
        int   digits[4];
        logic dp0;
        int   value;
        for (int k = 0; k < 4; k++) digits[k] = 15;
        dp0 = 1'bx;
        for (int i = 0; i < 8 * SCAN_DIV; i++) begin
            @(negedge CLK);
            case (bus.AN)
                4'b1110: begin digits[0] = decode_seg(bus.SEG); dp0 = bus.DP; end
                4'b1101: digits[1] = decode_seg(bus.SEG);
                4'b1011: digits[2] = decode_seg(bus.SEG);
                4'b0111: digits[3] = decode_seg(bus.SEG);
                default: ;
            endcase
        end
        value = digits[3] * 1000 + digits[2] * 100 + digits[1] * 10 + digits[0];
        checkOutput({name, "_value"}, 16'(value), 16'(exp_count));
        checkOutput({name, "_dp0"}, 16'(dp0), 16'(exp_dp0));
    endtask

    task automatic checkResetValues(input string name);
        checkOutput({name, "_an"},      16'(bus.AN),      16'h000e);
        checkOutput({name, "_seg"},     16'(bus.SEG),     16'h0040);
        checkOutput({name, "_dp"},      16'(bus.DP),      16'h0001);
        checkOutput({name, "_running"}, 16'(bus.RUNNING), 16'h0000);
        checkOutput({name, "_carry"},   16'(bus.CARRY),   16'h0000);
    endtask

    initial begin
        RST = 1'b1;
        bus.START = 1'b0;
        bus.STOP  = 1'b0;
        bus.CLEAR = 1'b0;
        an_table = '{4'b1110, 4'b1110, 4'b1101, 4'b1101, 4'b1011, 4'b1011, 4'b0111, 4'b0111, 4'b1110};
        vecs[0] = '{1'b1, 1'b1, 1'b0, 3, 1'b0, 11, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1, 1'b1, 0,  1'b1};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 3, 1'b0, 11, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 3, 1'b0, 11, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 3, 1'b0, 0,  1'b1};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 3, 1'b0, 0,  1'b1};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 3, 1'b0, 0,  1'b1};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 3, 1'b0, 0,  1'b1};

        waitCycles(2);
        checkResetValues("reset");
        RST = 1'b0;
        for (int i = 0; i < 9; i++) begin
            waitCycles(1);
            checkOutput($sformatf("an_step%0d", i), 16'(bus.AN), 16'(an_table[i]));
        end

        $display("[TB] count timing and pause/resume");
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("running_edge0", 16'(bus.RUNNING), 16'd0);
        waitCycles(1);
        checkOutput("running_edge1", 16'(bus.RUNNING), 16'd1);
        waitCycles(40);
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitCycles(20);
        checkOutput("running_paused", 16'(bus.RUNNING), 16'd0);
        readDisplay("after40", 10, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitCycles(2);
        checkOutput("running_resumed", 16'(bus.RUNNING), 16'd1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitCycles(3);
        readDisplay("resume", 11, 1'b0);

        $display("[TB] simultaneous command vectors");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].start, vecs[i].stop, vecs[i].clear);
            waitCycles(vecs[i].wait_n);
            checkOutput($sformatf("vec%0d_running", i), 16'(bus.RUNNING), 16'(vecs[i].exp_running));
            if (!vecs[i].exp_running) readDisplay($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_dp0);
        end

        $display("[TB] STOP and CLEAR on a terminal-count cycle");
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitForModel("wait_div2_a", M_RUN, 2, -1, 20);
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitCycles(3);
        checkOutput("stop_term_running", 16'(bus.RUNNING), 16'd0);
        readDisplay("stop_term", 1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitForModel("wait_div2_b", M_RUN, 2, -1, 20);
        applyStimulus(1'b0, 1'b0, 1'b1);
        waitCycles(3);
        checkOutput("clear_term_running", 16'(bus.RUNNING), 16'd0);
        readDisplay("clear_term", 0, 1'b1);
        checkOutput("carry_none_yet", 16'(carry_pulses), 16'd0);

        $display("[TB] 9999 wrap");
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitForModel("wait_9999", M_RUN, 0, 9999, 45000);
        waitCycles(3);
        checkOutput("carry_before_wrap", 16'(bus.CARRY), 16'd0);
        waitCycles(1);
        checkOutput("carry_at_wrap", 16'(bus.CARRY), 16'd1);
        waitCycles(1);
        checkOutput("carry_after_wrap", 16'(bus.CARRY), 16'd0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitCycles(3);
        readDisplay("wrap", 0, 1'b0);
        checkOutput("carry_pulses", 16'(carry_pulses), 16'd1);

        $display("[TB] reset mid-run");
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitForModel("wait_437", M_RUN, -1, 437, 3000);
        RST = 1'b1;
        waitCycles(1);
        checkResetValues("midrun_reset");
        RST = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitCycles(2);
        checkOutput("restart_running", 16'(bus.RUNNING), 16'd1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitCycles(3);
        readDisplay("restart", 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/counter_scan_controller.md
Name: counter_scan_controller

Overview:
- Sequences the seven-segment counter datapath.
- Owns the count-enable divider and a start/stop/clear FSM, and runs a 4-digit BCD up-counter only while enabled.
- Time-multiplexes the four digits onto one active-low seven-segment bus.
- Sits between the debounced push-button pulses and the board's anode/segment pins.

Parameters:
- COUNT_DIV, 20000000: clock cycles per count increment while running; divider counts 0..COUNT_DIV-1. Minimum 2.
- SCAN_DIV, 50000: clock cycles per digit-scan step; scan divider counts 0..SCAN_DIV-1. Minimum 2.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous reset, active-high.
- START  in  1  single-cycle pulse, debounced upstream.
- STOP  in  1  single-cycle pulse.
- CLEAR  in  1  single-cycle pulse.
- AN  out  4  digit anodes, active-low, one-hot-low.
- SEG  out  7  segments {g,f,e,d,c,b,a}, active-low.
- DP  out  1  decimal point, active-low.
- RUNNING  out  1  high while in RUN.
- CARRY  out  1  one-cycle pulse on 9999->0000 wrap.

Behaviour:
- Reset: one clock, one synchronous active-high reset (CLK, RST). On RST:
  - state=IDLE, BCD=0000, both dividers=0, scan index=0.
  - AN=4'b1110, SEG=7'b1000000, DP=1, RUNNING=0, CARRY=0.
  - RST overrides all other inputs in that cycle.
- FSM states IDLE, RUN, PAUSED. Input priority CLEAR > STOP > START.
  - Any state + CLEAR -> IDLE: BCD and count divider zeroed next cycle.
  - IDLE + START -> RUN. STOP in IDLE is ignored.
  - RUN + STOP -> PAUSED.
  - PAUSED + START -> RUN.
  - START and STOP in the same cycle: STOP wins in RUN; in IDLE the state stays IDLE; in PAUSED the state stays PAUSED.
  - RUNNING is registered and equals (state==RUN).
- Count divider:
  - Advances only in cycles where the state is RUN; holds its value in PAUSED, so resume continues the partial period.
  - Is 0 in IDLE.
  - On the RUN cycle where divider==COUNT_DIV-1: divider returns to 0 and BCD increments at the same edge.
  - Latency: START sampled at edge k gives RUN from edge k+1; first increment is visible after edge k+1+COUNT_DIV.
- BCD counter:
  - Four digits d3..d0, d0 least significant; each digit 0-9 with ripple carry.
  - 9999 -> 0000 with CARRY=1 for exactly that one cycle, registered alongside the wrap.
- Boundary cases:
  - STOP coinciding with a terminal-count cycle: the increment is applied, state -> PAUSED, divider -> 0.
  - CLEAR coinciding with a terminal-count cycle: the increment is discarded, BCD=0000, CARRY stays 0.
- Scan:
  - Free-running in all states.
  - At scan divider==SCAN_DIV-1, the index advances 0->1->2->3->0.
- Display outputs:
  - All registered, one-cycle lag after the scan-index or BCD change.
  - AN[i]=0 only for index i.
  - SEG shows digit i, with no blanking of leading zeros.
  - SEG codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - DP=0 only when state==PAUSED and index==0; otherwise DP=1.
- No combinational path from any input to any output.

Test Plan (COUNT_DIV=4, SCAN_DIV=2):
- Reset: RST high 2 cycles then low -> AN=1110, SEG=1000000, DP=1, RUNNING=0, CARRY=0; AN then steps 1110->1101->1011->0111->1110, one step every 2 cycles.
- Count timing: START pulse at edge 0 -> RUNNING=1 from edge 1; BCD=0001 after edge 5 and 0002 after edge 9. Over 40 RUN cycles BCD=0010 and SEG shows 1 on AN=1101.
- Pause/resume: STOP when divider=2 -> PAUSED, divider holds at 2, DP=0 whenever AN=1110. Wait 20 cycles with BCD unchanged, then START -> next increment occurs 3 cycles after RUN resumes (divider 2, 3, then wrap).
- Wrap: run from 9998 -> 9999 then 0000, CARRY high exactly one cycle coincident with the 0000 update.
- Simultaneous events:
  - START+STOP together in RUN -> PAUSED.
  - CLEAR+START together in PAUSED -> IDLE, BCD=0000.
  - STOP on a terminal cycle -> BCD increments, state PAUSED.
  - CLEAR on a terminal cycle -> BCD=0000, no CARRY.
- Reset mid-run: RST asserted while RUN at BCD=0437 -> all reset values on the next cycle; a later START restarts from 0000 with full COUNT_DIV latency.
